// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Purpose  : Shared AES definitions. Width constants, key-length encodings,
//            Nk/Nr constants, the key-schedule FSM state type, the forward
//            S-box table and the GF(2^8) helpers (xtime, inv_mix_col).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int TEXT_W = 128;

  typedef enum logic [1:0] {
    KEYLEN_128  = 2'd0,
    KEYLEN_192  = 2'd1,
    KEYLEN_256  = 2'd2,
    KEYLEN_RSVD = 2'd3
  } keylen_e;

  localparam logic [3:0] NK_128 = 4'd4;
  localparam logic [3:0] NK_192 = 4'd6;
  localparam logic [3:0] NK_256 = 4'd8;
  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } ks_state_e;

  // Forward S-box, entry 0 is the leftmost byte.
  localparam logic [0:255][BYTE_W-1:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [BYTE_W-1:0] sbox(input logic [BYTE_W-1:0] b);
    return SBOX_TBL[b];
  endfunction

  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
    return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
  endfunction

  // Multiply by a 4-bit constant; enough for the InvMixColumns coefficients.
  function automatic logic [BYTE_W-1:0] gf_mul_c(input logic [BYTE_W-1:0] b,
                                                 input logic [3:0]        c);
    logic [BYTE_W-1:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (c[0] ? b : 8'h00) ^ (c[1] ? x2 : 8'h00) ^
           (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [WORD_W-1:0] inv_mix_col(input logic [WORD_W-1:0] col);
    logic [BYTE_W-1:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gf_mul_c(a0, 4'd14) ^ gf_mul_c(a1, 4'd11) ^ gf_mul_c(a2, 4'd13) ^ gf_mul_c(a3, 4'd9),
            gf_mul_c(a0, 4'd9)  ^ gf_mul_c(a1, 4'd14) ^ gf_mul_c(a2, 4'd11) ^ gf_mul_c(a3, 4'd13),
            gf_mul_c(a0, 4'd13) ^ gf_mul_c(a1, 4'd9)  ^ gf_mul_c(a2, 4'd14) ^ gf_mul_c(a3, 4'd11),
            gf_mul_c(a0, 4'd11) ^ gf_mul_c(a1, 4'd13) ^ gf_mul_c(a2, 4'd9)  ^ gf_mul_c(a3, 4'd14)};
  endfunction

  // Reserved encoding falls back to AES-128.
  function automatic logic [3:0] keylen_to_nk(input logic [1:0] kl);
    logic [3:0] nk;
    case (keylen_e'(kl))
      KEYLEN_192: nk = NK_192;
      KEYLEN_256: nk = NK_256;
      default:    nk = NK_128;
    endcase
    return nk;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox_word.sv
`default_nettype none
// ============================================================================
// Module   : aes_sbox_word
// Purpose  : SubWord - applies the AES S-box to each byte of a 32-bit word.
// Ports    : word_i [31:0] in  - input word
//            word_o [31:0] out - substituted word
// Revision : 1.0 - initial release
// ============================================================================
module aes_sbox_word
  import aes_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  output logic [WORD_W-1:0] word_o
);

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    assign word_o[b*BYTE_W +: BYTE_W] = sbox(word_i[b*BYTE_W +: BYTE_W]);
  end

endmodule
`default_nettype wire

// File: rtl/aes_key_sched_seq.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_sched_seq
// Purpose  : Iterative AES-128/192/256 key schedule. One schedule word is
//            produced per cycle into an internal buffer; round keys are read
//            back by index through a registered port.
// Ports    : clk_i, rst_i (async, active-high)
//            start_i, keylen_i[1:0], key_i[KEY_W-1:0] - expansion request
//            ready_o, done_o, valid_o, nr_o[3:0]      - status
//            rk_idx_i[3:0] -> rk_o[127:0]             - round-key read (1 cycle)
//            rk_dec_o[127:0]                          - only with KEY_SCHED_INVMIX_EN
// Config   : `define KEY_SCHED_INVMIX_EN adds rk_dec_o (equivalent inverse
//            cipher round keys).
// Revision : 1.0 - initial release
// ============================================================================
module aes_key_sched_seq
  import aes_pkg::*;
#(
  parameter int MAX_WORDS = 60,
  parameter int KEY_W     = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        keylen_i,
  input  logic [KEY_W-1:0]  key_i,
  output logic              ready_o,
  output logic              done_o,
  output logic              valid_o,
  output logic [3:0]        nr_o,
  input  logic [3:0]        rk_idx_i,
  output logic [TEXT_W-1:0] rk_o
`ifdef KEY_SCHED_INVMIX_EN
  ,
  output logic [TEXT_W-1:0] rk_dec_o
`endif
);

  localparam int AW = $clog2(MAX_WORDS);

  // Normalise the key bus to 256 bits, MSB-aligned.
  logic [255:0] key_ext;
  if (KEY_W >= 256) begin : g_key_wide
    assign key_ext = key_i[KEY_W-1 -: 256];
  end else begin : g_key_narrow
    assign key_ext = {key_i, {(256-KEY_W){1'b0}}};
  end

  ks_state_e   state_q, state_d;
  logic [AW-1:0] i_q, i_d, total_q, total_d;
  logic [2:0]  j_q, j_d;
  logic [7:0]  rcon_q, rcon_d;
  logic [3:0]  nk_q, nk_d, nr_run_q, nr_run_d, nr_q, nr_d;
  logic        valid_q, valid_d, done_q, done_d;
  logic [TEXT_W-1:0] rk_q, rk_d;

  logic [WORD_W-1:0] word_mem [MAX_WORDS];

  logic              key_wr, exp_wr;
  logic [3:0]        nk_sel;
  logic [WORD_W-1:0] prev_word, back_word, sbox_in, sbox_out, temp, new_word;

  assign nk_sel    = keylen_to_nk(keylen_i);
  assign prev_word = word_mem[i_q - AW'(1)];
  assign back_word = word_mem[i_q - AW'(nk_q)];
  // RotWord only feeds the S-boxes on the rcon step; the AES-256 mid-key step
  // substitutes without rotation.
  assign sbox_in   = (j_q == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

  aes_sbox_word u_sbox (
    .word_i (sbox_in),
    .word_o (sbox_out)
  );

  always_comb begin
    temp = prev_word;
    if (j_q == 3'd0) begin
      temp = sbox_out ^ {rcon_q, 24'h0};
    end else if (nk_q == NK_256 && j_q == 3'd4) begin
      temp = sbox_out;
    end
    new_word = back_word ^ temp;
  end

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    rcon_d   = rcon_q;
    nk_d     = nk_q;
    nr_run_d = nr_run_q;
    total_d  = total_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    nr_d     = nr_q;
    key_wr   = 1'b0;
    exp_wr   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          nk_d     = nk_sel;
          nr_run_d = nk_sel + 4'd6;
          total_d  = AW'({nk_sel + 4'd7, 2'b00});  // 4*(Nr+1)
          i_d      = AW'(nk_sel);
          j_d      = 3'd0;
          rcon_d   = 8'h01;
          valid_d  = 1'b0;
          key_wr   = 1'b1;
          state_d  = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        exp_wr = 1'b1;
        i_d    = i_q + AW'(1);
        // j tracks i mod Nk incrementally.
        j_d    = (j_q == 3'(nk_q - 4'd1)) ? 3'd0 : j_q + 3'd1;
        if (j_q == 3'd0) begin
          rcon_d = xtime(rcon_q);
        end
        if (i_q == total_q - AW'(1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          valid_d = 1'b1;
          nr_d    = nr_run_q;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Schedule buffer: not reset, contents are masked by valid.
  always_ff @(posedge clk_i) begin
    if (key_wr) begin
      for (int k = 0; k < 8; k++) begin
        word_mem[k] <= key_ext[255-32*k -: 32];
      end
    end else if (exp_wr) begin
      word_mem[i_q] <= new_word;
    end
  end

  // Round-key read port.
  logic [AW-1:0]     rd_base;
  logic              rd_ok;
  logic [TEXT_W-1:0] rd_word;

  assign rd_base = AW'({rk_idx_i, 2'b00});
  assign rd_ok   = valid_q && (rk_idx_i <= nr_q);
  assign rd_word = {word_mem[rd_base], word_mem[rd_base + AW'(1)],
                    word_mem[rd_base + AW'(2)], word_mem[rd_base + AW'(3)]};
  assign rk_d    = rd_ok ? rd_word : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      i_q      <= '0;
      j_q      <= '0;
      rcon_q   <= '0;
      nk_q     <= '0;
      nr_run_q <= '0;
      total_q  <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      nr_q     <= '0;
      rk_q     <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      rcon_q   <= rcon_d;
      nk_q     <= nk_d;
      nr_run_q <= nr_run_d;
      total_q  <= total_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      nr_q     <= nr_d;
      rk_q     <= rk_d;
    end
  end

`ifdef KEY_SCHED_INVMIX_EN
  logic [TEXT_W-1:0] rk_dec_q, rk_dec_d;

  // First and last round keys pass through unchanged in the equivalent
  // inverse cipher.
  always_comb begin
    rk_dec_d = '0;
    if (rd_ok) begin
      if (rk_idx_i == 4'd0 || rk_idx_i == nr_q) begin
        rk_dec_d = rd_word;
      end else begin
        rk_dec_d = {inv_mix_col(rd_word[127:96]), inv_mix_col(rd_word[95:64]),
                    inv_mix_col(rd_word[63:32]),  inv_mix_col(rd_word[31:0])};
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rk_dec_q <= '0;
    end else begin
      rk_dec_q <= rk_dec_d;
    end
  end

  assign rk_dec_o = rk_dec_q;
`endif

  assign ready_o = (state_q == ST_IDLE);
  assign done_o  = done_q;
  assign valid_o = valid_q;
  assign nr_o    = nr_q;
  assign rk_o    = rk_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_sched_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_key_sched_seq
// Purpose  : Self-checking bench for aes_key_sched_seq. The reference model
//            derives the S-box from GF(2^8) inversion plus the affine map and
//            expands keys word by word with plain array arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_key_sched_seq;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic [1:0]   keylen_i;
  logic [255:0] key_i;
  logic         ready_o, done_o, valid_o;
  logic [3:0]   nr_o;
  logic [3:0]   rk_idx_i;
  logic [127:0] rk_o;
`ifdef KEY_SCHED_INVMIX_EN
  logic [127:0] rk_dec_o;
`endif

  always #5 clk_i = ~clk_i;

  aes_key_sched_seq #(.MAX_WORDS(60), .KEY_W(256)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .keylen_i (keylen_i),
    .key_i    (key_i),
    .ready_o  (ready_o),
    .done_o   (done_o),
    .valid_o  (valid_o),
    .nr_o     (nr_o),
    .rk_idx_i (rk_idx_i),
    .rk_o     (rk_o)
`ifdef KEY_SCHED_INVMIX_EN
    ,
    .rk_dec_o (rk_dec_o)
`endif
  );

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  sbox_m [256];
  logic [31:0] w_m [60];
  int          nk_m, nr_m;
  logic [3:0]  imc_coef [4];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, t;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ 8'h63;
      for (int n = 1; n < 5; n++) begin
        t = (inv << n) | (inv >> (8 - n));
        s = s ^ t;
      end
      sbox_m[x] = s;
    end
  endtask

  function automatic logic [31:0] sub_m(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  function automatic logic [7:0] rcon_m(input int n);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 1; k < n; k++) r = gmul(r, 8'h02);
    return r;
  endfunction

  task automatic model_expand(input logic [1:0] kl, input logic [255:0] key);
    logic [31:0] t;
    int tot;
    nk_m = (kl == 2'd1) ? 6 : (kl == 2'd2) ? 8 : 4;
    nr_m = nk_m + 6;
    tot  = 4 * (nr_m + 1);
    for (int i = 0; i < nk_m; i++) w_m[i] = key[255-32*i -: 32];
    for (int i = nk_m; i < tot; i++) begin
      t = w_m[i-1];
      if (i % nk_m == 0)
        t = sub_m({t[23:0], t[31:24]}) ^ {rcon_m(i / nk_m), 24'h0};
      else if (nk_m == 8 && i % nk_m == 4)
        t = sub_m(t);
      w_m[i] = w_m[i-nk_m] ^ t;
    end
  endtask

  function automatic logic [127:0] exp_rk(input int r);
    if (r > nr_m) return 128'h0;
    return {w_m[4*r], w_m[4*r+1], w_m[4*r+2], w_m[4*r+3]};
  endfunction

  function automatic logic [31:0] imc_m(input logic [31:0] w);
    logic [7:0] a [4];
    logic [7:0] o [4];
    for (int k = 0; k < 4; k++) a[k] = w[31-8*k -: 8];
    for (int row = 0; row < 4; row++) begin
      o[row] = 8'h00;
      for (int col = 0; col < 4; col++)
        o[row] = o[row] ^ gmul(a[col], {4'h0, imc_coef[(col - row + 4) % 4]});
    end
    return {o[0], o[1], o[2], o[3]};
  endfunction

  function automatic logic [127:0] exp_dec(input int r);
    logic [127:0] k;
    k = exp_rk(r);
    if (r == 0 || r >= nr_m) return k;
    return {imc_m(k[127:96]), imc_m(k[95:64]), imc_m(k[63:32]), imc_m(k[31:0])};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start(input logic [1:0] kl, input logic [255:0] key, output int waited);
    waited = 0;
    while (!ready_o && waited < 10) begin
      @(posedge clk_i); #1;
      waited++;
    end
    chk("ready_before_start", ready_o, 1);
    start_i  = 1'b1;
    keylen_i = kl;
    key_i    = key;
    @(posedge clk_i); #1;
    start_i  = 1'b0;
  endtask

  task automatic run_expand(input int exp_lat, input bit poke);
    int cnt;
    cnt = 0;
    chk("valid_cleared_on_start", valid_o, 0);
    chk("busy_in_expand", ready_o, 0);
    while (!done_o && cnt < 200) begin
      if (poke && cnt == 10) begin
        start_i  = 1'b1;
        keylen_i = 2'd2;
        key_i    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end else begin
        start_i = 1'b0;
      end
      @(posedge clk_i); #1;
      cnt++;
    end
    start_i = 1'b0;
    chk("done_latency", cnt, exp_lat);
    chk("valid_at_done", valid_o, 1);
    chk("nr_at_done", nr_o, nr_m);
  endtask

  task automatic check_reads();
    for (int r = 0; r < 16; r++) begin
      rk_idx_i = 4'(r);
      @(posedge clk_i); #1;
      if (r == 0) begin
        chk("done_single_pulse", done_o, 0);
        chk("idle_after_done", ready_o, 1);
      end
      chk($sformatf("rk[%0d]", r), rk_o, exp_rk(r));
`ifdef KEY_SCHED_INVMIX_EN
      chk($sformatf("rk_dec[%0d]", r), rk_dec_o, exp_dec(r));
`endif
    end
  endtask

  task automatic full_run(input logic [1:0] kl, input logic [255:0] key,
                          input bit poke, input bit b2b, input bit reads);
    int waited;
    model_expand(kl, key);
    pulse_start(kl, key, waited);
    if (b2b) chk("b2b_start_wait", waited, 1);
    run_expand(4 * (nr_m + 1) - nk_m, poke);
    if (reads) check_reads();
  endtask

  task automatic read_rk(input int idx, output logic [127:0] v);
    rk_idx_i = 4'(idx);
    @(posedge clk_i); #1;
    v = rk_o;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] v;
    logic [255:0] rkey;
    logic [1:0]   rkl;
    int           waited;
    bit           leaked;

    imc_coef[0] = 4'd14; imc_coef[1] = 4'd11; imc_coef[2] = 4'd13; imc_coef[3] = 4'd9;
    build_sbox();

    rst_i = 1'b1; start_i = 1'b0; keylen_i = 2'd0; key_i = '0; rk_idx_i = 4'd0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready", ready_o, 1);
    chk("rst_done", done_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_nr", nr_o, 0);
    chk("rst_rk", rk_o, 0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // AES-128 with a start poked mid-expansion.
    full_run(2'd0, K128, 1'b1, 1'b0, 1'b1);
    chk("aes128_nr", nr_o, 10);
    read_rk(1, v);  chk("aes128_rk1", v, 128'ha0fafe1788542cb123a339392a6c7605);
    read_rk(10, v); chk("aes128_rk10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_rk(13, v); chk("aes128_idx13_masked", v, 128'h0);

    // AES-256 immediately followed by AES-192.
    full_run(2'd2, K256, 1'b0, 1'b0, 1'b0);
    full_run(2'd1, K192, 1'b0, 1'b1, 1'b1);
    read_rk(12, v); chk("aes192_rk12", v, 128'he98ba06f448c773c8ecc720401002202);
    full_run(2'd2, K256, 1'b0, 1'b0, 1'b1);
    read_rk(14, v); chk("aes256_rk14", v, 128'hfe4890d1e6188d0b046df344706c631e);

    // Random keys and key lengths, including the reserved encoding.
    for (int n = 0; n < 8; n++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rkl  = 2'($urandom_range(0, 3));
      full_run(rkl, rkey, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    end

    // Reset abort in the middle of an AES-256 run.
    model_expand(2'd2, K256);
    pulse_start(2'd2, K256, waited);
    repeat (19) begin @(posedge clk_i); #1; end
    rst_i = 1'b1;
    #1;
    chk("abort_ready", ready_o, 1);
    chk("abort_valid", valid_o, 0);
    chk("abort_done", done_o, 0);
    chk("abort_nr", nr_o, 0);
    chk("abort_rk", rk_o, 0);
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b0;
    leaked = 1'b0;
    repeat (60) begin
      @(posedge clk_i); #1;
      if (done_o || valid_o) leaked = 1'b1;
    end
    chk("abort_no_partial_schedule", leaked, 0);

    full_run(2'd0, K128, 1'b0, 1'b0, 1'b1);
    read_rk(1, v);  chk("post_abort_rk1", v, 128'ha0fafe1788542cb123a339392a6c7605);
    read_rk(10, v); chk("post_abort_rk10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_key_sched_seq.md
# aes_key_sched_seq

Sequential, parameter-free-width AES key schedule that replaces the fully combinational 128-bit expansion with an iterative engine. It supports AES-128, AES-192 and AES-256, selected per request. It generates one 32-bit schedule word per cycle into an internal word buffer. The cipher datapath reads round keys by index through a registered read port. The engine sits between the key-load interface and the round pipeline.

## Interface
- `MAX_WORDS`, default 60: word-buffer depth; must be ≥ 60 for AES-256 support.
- `KEY_W`, default 256: width of the key input bus.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `start_i` in 1: request expansion; accepted only when `ready_o`=1.
- `keylen_i` in 2: key length, sampled with `start_i`.
  - 0 = 128, 1 = 192, 2 = 256.
  - 3 = reserved; treated as 128.
- `key_i` in KEY_W: cipher key, MSB-aligned.
  - W[0] = key_i[255:224].
  - Bits below the key length are ignored.
- `ready_o` out 1: engine idle; a start is accepted.
- `done_o` out 1: one-cycle pulse when the last word is written.
- `valid_o` out 1: the schedule in the buffer is complete and matches the last accepted key.
- `nr_o` out 4: round count of the stored schedule (10/12/14); 0 until first completion.
- `rk_idx_i` in 4: round-key index to read, 0..Nr.
- `rk_o` out 128: round key {W[4r], W[4r+1], W[4r+2], W[4r+3]}; registered.
- `rk_dec_o` out 128: present only with `KEY_SCHED_INVMIX_EN`.

## Operation
- **FSM states:** IDLE, EXPAND, DONE.
  - IDLE: `ready_o`=1.
  - DONE is a single cycle, then the FSM returns to IDLE. `valid_o` stays 1.
- **Start accepted (IDLE & `start_i`):**
  - Latch Nk = 4/6/8, Nr = Nk+6, total = 4·(Nr+1) = 44/52/60.
  - Write W[0..Nk-1] from `key_i` in that same edge.
  - Set i=Nk, j=0 (i mod Nk), rcon=8'h01.
  - Clear `valid_o`. Go to EXPAND.
- **EXPAND, per cycle:** write W[i] = W[i-Nk] ^ temp, where:
  - j==0: temp = SubWord(RotWord(W[i-1])) ^ {rcon,24'h0}; then rcon ← xtime(rcon).
  - Nk==8 and j==4: temp = SubWord(W[i-1]).
  - Otherwise: temp = W[i-1].
  - Then i++ and j wraps at Nk-1 → 0. No divider is used.
- **rcon sequence:** 01,02,04,08,10,20,40,80,1b,36. xtime is a left shift with conditional ^8'h1b.
- **Completion:** the cycle that writes W[total-1] also moves the FSM to DONE. In that cycle `done_o` pulses, `valid_o` goes to 1 and `nr_o` is set to Nr.
- **`start_i` rules:**
  - Ignored while in EXPAND or DONE. There is no queuing.
  - A new start in IDLE invalidates the previous schedule immediately.
- **Read port:** `rk_o` ← buffer at `rk_idx_i` on every edge. It reads 128'h0 if `valid_o`=0 or `rk_idx_i` > `nr_o`.
- **Reset:** the FSM goes to IDLE and all outputs are 0 except `ready_o`=1.
  - Covers `done_o`, `valid_o`, `nr_o`, `rk_o`, `rk_dec_o`.
  - Buffer contents are don't-care; they are masked by `valid_o`.
  - Reset during EXPAND aborts the run; no partial schedule becomes valid.

## Timing
- **Start → `done_o` latency:** 40 / 46 / 52 edges (total − Nk) for 128 / 192 / 256.
- **First legal start after `done_o`:** the cycle after `done_o` (IDLE).
- **Read latency:** 1 cycle from `rk_idx_i` to `rk_o`. A fully pipelined index stream is supported.
- **Critical path:** one SubWord (4 S-boxes) plus two XORs per cycle.

## Configuration
- **`KEY_SCHED_INVMIX_EN` defined:**
  - Adds `rk_dec_o`, registered with the same latency as `rk_o`.
  - Equals InvMixColumns(rk) for 1 ≤ `rk_idx_i` ≤ Nr−1 (equivalent inverse cipher keys).
  - Equals rk unchanged for index 0 and Nr.
  - Is 0 under the same masking rules as `rk_o`.
- **Undefined:** the port and its logic are absent; all other behaviour is identical.

## Structure
- **Package `aes_pkg`:**
  - Key-length encodings and Nk/Nr constants.
  - The S-box table as a function.
  - `xtime` and `inv_mix_col` functions.
  - BYTE/WORD/TEXT width constants.
- **Sub-module `aes_sbox_word`:** SubWord over 32 bits, four S-box instances. It is reusable by the round datapath.

## Test plan
- **AES-128:** key 2b7e151628aed2a6abf7158809cf4f3c.
  - `done_o` after 40 cycles; `nr_o`=10.
  - rk[1]=a0fafe1788542cb123a339392a6c7605.
  - rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
- **AES-192:** key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b.
  - `done_o` after 46 cycles.
  - rk[12]=e98ba06f448c773c8ecc720401002202.
- **AES-256:** key 603deb10…0914dff4 (FIPS-197 A.3).
  - `done_o` after 52 cycles.
  - rk[14]=fe4890d1e6188d0b046df344706c631e.
- **Protocol:**
  - Start pulsed again mid-EXPAND → ignored; results unchanged.
  - rk_idx_i=13 with `nr_o`=10 → rk_o=0.
  - Back-to-back starts → second accepted the cycle after `done_o`.
- **Reset abort:** `rst_i` asserted at cycle 20 of an AES-256 run.
  - `ready_o`=1 and `valid_o`=0 immediately.
  - A fresh AES-128 run then matches the AES-128 scenario.
- **`KEY_SCHED_INVMIX_EN`:**
  - `rk_dec_o` equals the model's InvMixColumns for rounds 1..Nr−1.
  - Equals `rk_o` for rounds 0 and Nr, for all three key lengths.
